// File: rtl/counter_seq.sv
// Armed up/down counter: counts user steps in RUN, stops in DONE on a terminal-count match.
// One-cycle latency from inputs to registered outputs; no backpressure, every qualifying step is taken.
module counter_seq #(
   parameter int WIDTH    = 4,
   parameter bit MODE_SAT = 1'b0
) (
   input  logic             clk,
   input  logic             R,
   input  logic             start,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             E,
   input  logic             dir,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] cnt_step;
   logic             tc_nxt, ovf_nxt;
   logic             at_bound;

   // Boundary is direction-dependent: all-ones going up, zero going down.
   assign at_bound = dir ? (cnt == CNT_MAX) : (cnt == '0);

   always_comb begin
      if (at_bound && MODE_SAT) begin
         cnt_step = cnt;
      end else if (dir) begin
         cnt_step = cnt + CNT_ONE;
      end else begin
         cnt_step = cnt - CNT_ONE;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tc_nxt    = 1'b0;
      ovf_nxt   = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (ld) begin
         cnt_nxt = ld_val;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end
            end
            RUN: begin
               // start re-arms the run and takes precedence over a step.
               if (start) begin
                  cnt_nxt = '0;
               end else if (E) begin
                  cnt_nxt = cnt_step;
                  ovf_nxt = at_bound;
                  if (cnt == data) begin
                     tc_nxt    = 1'b1;
                     state_nxt = DONE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         state <= IDLE;
         cnt   <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tc    <= tc_nxt;
         ovf   <= ovf_nxt;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: wrap and saturate instances share stimulus; expectations go through a scoreboard queue.
module tb_counter_seq;

   typedef struct packed {
      logic [3:0] cnt;
      logic       tc;
      logic       ovf;
      logic       busy;
      logic       done;
   } out_t;

   typedef struct {
      logic       r, start, clr, ld;
      logic [3:0] ld_val;
      logic       e, dir;
      logic [3:0] data;
      out_t       e0, e1;
   } vec_t;

   typedef struct {
      int   id;
      out_t e0, e1;
   } exp_t;

   logic       clk = 1'b0;
   logic       R = 1'b0, start = 1'b0, clr = 1'b0, ld = 1'b0, E = 1'b0, dir = 1'b0;
   logic [3:0] ld_val = '0, data = '0;
   logic [3:0] cnt0, cnt1;
   logic       tc0, ovf0, busy0, done0, tc1, ovf1, busy1, done1;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   counter_seq #(.WIDTH(4), .MODE_SAT(1'b0)) dut0 (
      .clk(clk), .R(R), .start(start), .clr(clr), .ld(ld), .ld_val(ld_val),
      .E(E), .dir(dir), .data(data),
      .cnt(cnt0), .tc(tc0), .ovf(ovf0), .busy(busy0), .done(done0)
   );

   counter_seq #(.WIDTH(4), .MODE_SAT(1'b1)) dut1 (
      .clk(clk), .R(R), .start(start), .clr(clr), .ld(ld), .ld_val(ld_val),
      .E(E), .dir(dir), .data(data),
      .cnt(cnt1), .tc(tc1), .ovf(ovf1), .busy(busy1), .done(done1)
   );

   function automatic out_t o(int c, bit t, bit f, bit b, bit d);
      out_t r;
      r.cnt  = 4'(c);
      r.tc   = t;
      r.ovf  = f;
      r.busy = b;
      r.done = d;
      return r;
   endfunction

   function automatic vec_t v(bit r, bit st, bit cl, bit l, int lv, bit e, bit d,
                              int dat, out_t x0, out_t x1);
      vec_t t;
      t.r = r; t.start = st; t.clr = cl; t.ld = l; t.ld_val = 4'(lv);
      t.e = e; t.dir = d; t.data = 4'(dat); t.e0 = x0; t.e1 = x1;
      return t;
   endfunction

   task automatic step(input vec_t t, input int id);
      exp_t x;
      @(negedge clk);
      #1;
      R = t.r; start = t.start; clr = t.clr; ld = t.ld; ld_val = t.ld_val;
      E = t.e; dir = t.dir; data = t.data;
      x.id = id; x.e0 = t.e0; x.e1 = t.e1;
      exp_q.push_back(x);
   endtask

   // Outputs for the edge just taken are compared on the following falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t x;
         out_t a0, a1;
         x  = exp_q.pop_front();
         a0 = {cnt0, tc0, ovf0, busy0, done0};
         a1 = {cnt1, tc1, ovf1, busy1, done1};
         n_cmp = n_cmp + 1;
         if (a0 !== x.e0) begin
            n_bad = n_bad + 1;
            $display("FAIL wrap_vec%0d: got cnt=%0d tc=%b ovf=%b busy=%b done=%b, want cnt=%0d tc=%b ovf=%b busy=%b done=%b",
                     x.id, a0.cnt, a0.tc, a0.ovf, a0.busy, a0.done,
                     x.e0.cnt, x.e0.tc, x.e0.ovf, x.e0.busy, x.e0.done);
         end
         n_cmp = n_cmp + 1;
         if (a1 !== x.e1) begin
            n_bad = n_bad + 1;
            $display("FAIL sat_vec%0d: got cnt=%0d tc=%b ovf=%b busy=%b done=%b, want cnt=%0d tc=%b ovf=%b busy=%b done=%b",
                     x.id, a1.cnt, a1.tc, a1.ovf, a1.busy, a1.done,
                     x.e1.cnt, x.e1.tc, x.e1.ovf, x.e1.busy, x.e1.done);
         end
      end
   end

   initial begin
      out_t z, run0;
      z    = o(0, 0, 0, 0, 0);
      run0 = o(0, 0, 0, 1, 0);
      //            R st cl ld lv E  d  dat  dut0               dut1
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, z, z));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 0, z, z));
      tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 3, run0, run0));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 3, o(1, 0, 0, 1, 0), o(1, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 3, o(2, 0, 0, 1, 0), o(2, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 3, o(3, 0, 0, 1, 0), o(3, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 3, o(4, 1, 0, 0, 1), o(4, 1, 0, 0, 1)));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 3, o(4, 0, 0, 0, 1), o(4, 0, 0, 0, 1)));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 4, o(4, 0, 0, 0, 1), o(4, 0, 0, 0, 1)));
      tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 4, run0, run0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, run0, run0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 5, run0, run0));
      tbl.push_back(v(1, 0, 0, 1, 15, 0, 1, 5, o(15, 0, 0, 1, 0), o(15, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 9, o(0, 0, 1, 1, 0), o(15, 0, 1, 1, 0)));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 9, o(0, 0, 0, 1, 0), o(15, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 0, 1, 2, 0, 0, 9, o(2, 0, 0, 1, 0), o(2, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, o(1, 0, 0, 1, 0), o(1, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, o(0, 0, 0, 1, 0), o(0, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, o(15, 1, 1, 0, 1), o(0, 1, 1, 0, 1)));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, o(15, 0, 0, 0, 1), o(0, 0, 0, 0, 1)));
      tbl.push_back(v(1, 1, 0, 0, 0, 1, 1, 0, run0, run0));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 7, o(1, 0, 0, 1, 0), o(1, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 0, 1, 9, 1, 1, 9, o(9, 0, 0, 1, 0), o(9, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 1, 0, 0, 1, 1, 9, z, z));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 0, z, z));
      tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, run0, run0));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 5, o(1, 0, 0, 1, 0), o(1, 0, 0, 1, 0)));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, z, z));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 0, z, z));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 0, z, z));
      tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, run0, run0));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 0, o(1, 1, 0, 0, 1), o(1, 1, 0, 0, 1)));
      tbl.push_back(v(1, 0, 1, 0, 0, 0, 1, 0, z, z));
      tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, run0, run0));
      tbl.push_back(v(1, 0, 1, 0, 0, 1, 0, 8, z, z));
      tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, run0, run0));
      tbl.push_back(v(1, 0, 0, 1, 5, 1, 0, 0, o(5, 0, 0, 1, 0), o(5, 0, 0, 1, 0)));
      tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, z, z));

      foreach (tbl[i]) step(tbl[i], i);

      // Full-range up count: data always 8 away from the count so it never matches.
      step(v(1, 1, 0, 0, 0, 0, 1, 0, run0, run0), 100);
      for (int k = 0; k < 16; k++) begin
         out_t x0, x1;
         x0 = o((k + 1) % 16, 0, (k == 15), 1, 0);
         x1 = o((k == 15) ? 15 : k + 1, 0, (k == 15), 1, 0);
         step(v(1, 0, 0, 0, 0, 1, 1, (k + 8) % 16, x0, x1), 101 + k);
      end
      // The two instances now diverge: wrap matches at 0, saturate matches at 15 on a boundary.
      step(v(1, 0, 0, 0, 0, 1, 1, 0, o(1, 1, 0, 0, 1), o(15, 0, 1, 1, 0)), 120);
      step(v(1, 0, 0, 0, 0, 1, 1, 15, o(1, 0, 0, 0, 1), o(15, 1, 1, 0, 1)), 121);
      step(v(1, 0, 0, 0, 0, 0, 1, 15, o(1, 0, 0, 0, 1), o(15, 0, 0, 0, 1)), 122);
      step(v(1, 0, 1, 0, 0, 0, 1, 0, z, z), 123);

      repeat (3) @(negedge clk);
      #2;
      n_cmp = n_cmp + 1;
      if (exp_q.size() != 0) begin
         n_bad = n_bad + 1;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/counter_seq.md
COUNTER_SEQ -- requirements
Module: counter_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- WIDTH, 4, counter/compare width in bits; legal range 2..16.
- MODE_SAT, 0, boundary mode: 0 = wrap around, 1 = saturate.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on its rising edge.
- R, input, 1, reset; synchronous, active-low.
- start, input, 1, arm a new count run.
- clr, input, 1, synchronous clear back to IDLE.
- ld, input, 1, load ld_val into the counter.
- ld_val, input, WIDTH, load value.
- E, input, 1, count enable (one user step).
- dir, input, 1, direction: 1 = up, 0 = down.
- data, input, WIDTH, terminal compare value.
- cnt, output, WIDTH, current count (registered).
- tc, output, 1, terminal-count pulse (registered, one cycle).
- ovf, output, 1, boundary pulse (registered, one cycle).
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE.

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE).
REQ-004 Per-cycle priority when R is high SHALL be: clr > ld > start > E.
REQ-005 clr=1 in any state SHALL force IDLE and cnt=0, and SHALL leave tc=0 and ovf=0 on the next cycle.
REQ-006 ld=1 (clr=0) SHALL set cnt=ld_val and leave the state unchanged; in that cycle start and E SHALL be ignored, and no compare, tc or ovf SHALL occur.
REQ-007 In IDLE, start=1 SHALL set cnt=0 and move to RUN; E SHALL be ignored in IDLE.
REQ-008 In DONE, start=1 SHALL set cnt=0 and move to RUN; otherwise cnt SHALL hold and E SHALL be ignored.
REQ-009 In RUN, E=1 SHALL compare the pre-update cnt against data; on a match, tc SHALL be 1 on the next cycle and the state SHALL move to DONE.
REQ-010 In RUN with E=1, cnt SHALL step by one in the direction dir, including on the matching step (same semantics as the existing user counter).
REQ-011 Up boundary: dir=1 with cnt=2^WIDTH-1. MODE_SAT=0 SHALL give cnt=0; MODE_SAT=1 SHALL hold cnt. Both SHALL give ovf=1 for one cycle.
REQ-012 Down boundary: dir=0 with cnt=0. MODE_SAT=0 SHALL give cnt=2^WIDTH-1; MODE_SAT=1 SHALL hold cnt. Both SHALL give ovf=1 for one cycle.
REQ-013 A match and a boundary in the same step SHALL assert tc and ovf together.
REQ-014 tc and ovf SHALL be 0 in every cycle not caused by a qualifying step; neither SHALL assert for two consecutive cycles from a single step.
REQ-015 In RUN with E=0, cnt SHALL hold and tc and ovf SHALL be 0.
REQ-016 data SHALL be sampled only in the E=1 cycle; data changes at any other time SHALL have no effect.
REQ-017 All arithmetic SHALL be modulo 2^WIDTH, with no carry beyond WIDTH bits.
REQ-018 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-019 R=0 at a rising clk edge SHALL set state=IDLE, cnt=0, tc=0, ovf=0, busy=0 and done=0, overriding all other inputs.
REQ-020 R=0 asserted mid-RUN SHALL abort the run; a tc pending from that same edge SHALL NOT assert.
REQ-021 After R returns high, the block SHALL stay in IDLE until start=1.

Verification
REQ-022 Basic run (WIDTH=4, MODE_SAT=0, dir=1, data=3): start, then E high for 4 cycles -> tc=1 exactly in the cycle after the 4th E, cnt=4, done=1; further E pulses leave cnt=4.
REQ-023 Up wrap (MODE_SAT=0, dir=1): ld_val=15 loaded, data=9, one E -> cnt=0, ovf=1 for one cycle, tc=0. Same stimulus with MODE_SAT=1 -> cnt=15, ovf=1.
REQ-024 Down count (dir=0): ld_val=2, data=0, three E pulses -> cnt goes 1, 0, then 15. tc=1 and ovf=1 together after the 3rd E, then DONE.
REQ-025 Priority: in RUN, ld=1, E=1 and clr=0 with ld_val=data -> cnt=ld_val, tc=0. Next cycle, clr=1 with E=1 -> IDLE, cnt=0.
REQ-026 Reset mid-run: R=0 on the same edge as a matching E -> cnt=0, tc=0, busy=0; after R goes high, E is ignored until start.
REQ-027 Restart from DONE: start=1 and E=1 in the same cycle -> cnt=0, busy=1, E ignored, tc=0.
